// File: rtl/cpu_pkg.sv
// Shared definitions for the UART program loader: upg address geometry and
// loader state encoding.
package cpu_pkg;

  localparam int UPG_ADR_W    = 15;
  localparam int DMEM_SEL_BIT = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } upg_state_t;

  // High address bit routes a write to data memory instead of the instruction ROM.
  function automatic logic adr_is_dmem(input logic [UPG_ADR_W-1:0] adr);
    return adr[DMEM_SEL_BIT];
  endfunction

endpackage

// File: rtl/upg_word_assembler.sv
// Collects UART bytes into a little-endian 32-bit word; the first byte lands in [7:0].
module upg_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        word_full
);

  logic [31:0] word;
  logic [1:0]  idx;

  // Bytes enter at the top and shift down, so after four loads byte 0 sits in [7:0].
  assign word_nxt  = load ? {byte_in, word[31:8]} : word;
  assign word_full = load && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 2'd0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (load) begin
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    word <= word_nxt;
  end

endmodule

// File: rtl/upg_loader_ctrl.sv
// UART program-loader: reads a 16-bit word count then N little-endian words and
// writes them through the upg_* port while holding the CPU off the memories.
module upg_loader_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int ADR_W          = UPG_ADR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  output logic             rx_ready_o,
  output logic             upg_wen_o,
  output logic [ADR_W-1:0] upg_adr_o,
  output logic [31:0]      upg_dat_o,
  output logic             upg_done_o,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  upg_state_t       state;
  logic [15:0]      word_total;
  logic [15:0]      word_cnt;
  logic [TMO_W-1:0] idle_cnt;
  logic             accept;
  logic             asm_clr;
  logic             asm_load;
  logic             asm_full;
  logic [31:0]      asm_word;

  assign accept   = rx_valid_i && rx_ready_o;
  assign asm_clr  = (state != DATA) && (state != WRITE);
  assign asm_load = accept && (state == DATA);

  upg_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .load      (asm_load),
    .byte_in   (rx_data_i),
    .word_nxt  (asm_word),
    .word_full (asm_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_total <= '0;
      word_cnt   <= '0;
      idle_cnt   <= '0;
      rx_ready_o <= 1'b0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b1;
      cpu_hold_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start_i) begin
            state      <= HDR0;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            upg_adr_o  <= '0;
            rx_ready_o <= 1'b1;
            upg_done_o <= 1'b0;
            cpu_hold_o <= 1'b1;
            busy_o     <= 1'b1;
            err_o      <= 1'b0;
          end
        end
        HDR0, HDR1, DATA: begin
          if (accept) begin
            idle_cnt <= '0;
            case (state)
              HDR0: begin
                word_total[7:0] <= rx_data_i;
                state           <= HDR1;
              end
              HDR1: begin
                word_total[15:8] <= rx_data_i;
                if (rx_data_i[7]) begin
                  state      <= ERR;
                  rx_ready_o <= 1'b0;
                  busy_o     <= 1'b0;
                  err_o      <= 1'b1;
                end else if ((rx_data_i == 8'd0) && (word_total[7:0] == 8'd0)) begin
                  state      <= DONE;
                  rx_ready_o <= 1'b0;
                  upg_done_o <= 1'b1;
                  cpu_hold_o <= 1'b0;
                  busy_o     <= 1'b0;
                end else begin
                  state     <= DATA;
                  word_cnt  <= '0;
                  upg_adr_o <= '0;
                end
              end
              default: begin
                if (asm_full) begin
                  state      <= WRITE;
                  rx_ready_o <= 1'b0;
                  upg_wen_o  <= 1'b1;
                  upg_dat_o  <= asm_word;
                end
              end
            endcase
          end else if (idle_cnt == TMO_LAST) begin
            // Sender went silent: abort but keep the CPU held off the half-loaded image.
            state      <= ERR;
            rx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        WRITE: begin
          upg_adr_o <= upg_adr_o + 1'b1;
          word_cnt  <= word_cnt + 16'd1;
          if ((word_cnt + 16'd1) == word_total) begin
            state      <= DONE;
            upg_done_o <= 1'b1;
            cpu_hold_o <= 1'b0;
            busy_o     <= 1'b0;
          end else begin
            state      <= DATA;
            rx_ready_o <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upg_loader_ctrl.sv
// Directed bench for upg_loader_ctrl: header parsing, word writes, flow control,
// timeout abort and asynchronous reset during a load.
module tb_upg_loader_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  logic [14:0] wr_adr[$];
  logic [31:0] wr_dat[$];

  upg_loader_ctrl #(
    .TIMEOUT_CYCLES (100),
    .ADR_W          (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upg_wen_o) begin
      wr_adr.push_back(upg_adr_o);
      wr_dat.push_back(upg_dat_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Presents a byte at a negedge and holds it until the DUT is ready, then drops valid
  // on the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) check_eq("rx_ready_wait", 32'(rx_ready_o), 32'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check_eq("rst_wen",      32'(upg_wen_o),  32'd0);
    check_eq("rst_adr",      32'(upg_adr_o),  32'd0);
    check_eq("rst_dat",      upg_dat_o,       32'd0);
    check_eq("rst_done",     32'(upg_done_o), 32'd1);
    check_eq("rst_hold",     32'(cpu_hold_o), 32'd0);
    check_eq("rst_busy",     32'(busy_o),     32'd0);
    check_eq("rst_err",      32'(err_o),      32'd0);
    rst = 1'b1;

    // Byte offered in IDLE is never taken
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hAA;
    repeat (3) @(negedge clk);
    check_eq("idle_rx_ready", 32'(rx_ready_o), 32'd0);
    check_eq("idle_busy",     32'(busy_o),     32'd0);
    rx_valid_i = 1'b0;

    // Two-word load
    pulse_start();
    check_eq("start_done", 32'(upg_done_o), 32'd0);
    check_eq("start_hold", 32'(cpu_hold_o), 32'd1);
    check_eq("start_busy", 32'(busy_o),     32'd1);
    check_eq("start_rdy",  32'(rx_ready_o), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check_eq("w1_wen", 32'(upg_wen_o), 32'd1);
    check_eq("w1_adr", 32'(upg_adr_o), 32'd1);
    check_eq("w1_dat", upg_dat_o,      32'hDEADBEEF);
    @(negedge clk);
    check_eq("done_done", 32'(upg_done_o), 32'd1);
    check_eq("done_hold", 32'(cpu_hold_o), 32'd0);
    check_eq("done_busy", 32'(busy_o),     32'd0);
    check_eq("done_wen",  32'(upg_wen_o),  32'd0);
    @(negedge clk);
    check_eq("ld2_wr_count", 32'(wr_adr.size()), 32'd2);
    check_eq("ld2_adr0", 32'(wr_adr[0]), 32'd0);
    check_eq("ld2_dat0", wr_dat[0],      32'h12345678);
    check_eq("ld2_adr1", 32'(wr_adr[1]), 32'd1);
    check_eq("ld2_dat1", wr_dat[1],      32'hDEADBEEF);

    // Zero-length header
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    check_eq("zero_done", 32'(upg_done_o), 32'd1);
    check_eq("zero_hold", 32'(cpu_hold_o), 32'd0);
    @(negedge clk);
    check_eq("zero_wr_count", 32'(wr_adr.size()), 32'd2);

    // Bad header: count[15] set
    pulse_start();
    send_byte(8'h00); send_byte(8'h80);
    check_eq("bad_err",  32'(err_o),      32'd1);
    check_eq("bad_done", 32'(upg_done_o), 32'd0);
    check_eq("bad_hold", 32'(cpu_hold_o), 32'd1);
    check_eq("bad_rdy",  32'(rx_ready_o), 32'd0);

    // Timeout after partial word; start from ERR clears err first
    pulse_start();
    check_eq("restart_err", 32'(err_o), 32'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    n = 0;
    while (!err_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_cycles", 32'(n),          32'd100);
    check_eq("tmo_err",    32'(err_o),      32'd1);
    check_eq("tmo_hold",   32'(cpu_hold_o), 32'd1);
    check_eq("tmo_done",   32'(upg_done_o), 32'd0);
    pulse_start();
    check_eq("tmo_clear_err", 32'(err_o),  32'd0);
    check_eq("tmo_restart",   32'(busy_o), 32'd1);

    // Flow control through WRITE and start ignored during DATA
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h55;
    check_eq("fc_wen",      32'(upg_wen_o),  32'd1);
    check_eq("fc_rdy_wr",   32'(rx_ready_o), 32'd0);
    send_byte(8'h55);
    pulse_start();
    check_eq("ign_busy", 32'(busy_o),    32'd1);
    check_eq("ign_adr",  32'(upg_adr_o), 32'd1);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    repeat (3) @(negedge clk);
    check_eq("fc_wr_count", 32'(wr_adr.size()), 32'd4);
    check_eq("fc_adr0", 32'(wr_adr[2]), 32'd0);
    check_eq("fc_dat0", wr_dat[2],      32'h44332211);
    check_eq("fc_adr1", 32'(wr_adr[3]), 32'd1);
    check_eq("fc_dat1", wr_dat[3],      32'h88776655);
    check_eq("fc_done", 32'(upg_done_o), 32'd1);

    // Asynchronous reset between data bytes 2 and 3
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hA1); send_byte(8'hA2);
    rst = 1'b0;
    #1;
    check_eq("arst_done", 32'(upg_done_o), 32'd1);
    check_eq("arst_hold", 32'(cpu_hold_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o),     32'd0);
    check_eq("arst_rdy",  32'(rx_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    check_eq("arst_wen", 32'(upg_wen_o), 32'd1);
    check_eq("arst_adr", 32'(upg_adr_o), 32'd0);
    check_eq("arst_dat", upg_dat_o,      32'hC4C3C2C1);
    repeat (2) @(negedge clk);
    check_eq("arst_wr_count", 32'(wr_adr.size()), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upg_loader_ctrl.md
Name: upg_loader_ctrl

Overview:
- UART program-loader controller. Takes the received UART byte stream, assembles little-endian 32-bit words and sequences them into the upg_* write port of instruction/data memory.
- Holds the CPU while a load is in progress and hands the memory ports back to the CPU when the load ends.
- Sits between the UART receiver and the memory/program-ROM upg_* ports at cpu_top level.

Parameters:
- TIMEOUT_CYCLES, 10_000_000, max idle cycles between bytes before the load aborts.
- ADR_W, 15, upg word-address width; bit ADR_W-1 selects data memory (1) or instruction ROM (0).

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle request to begin a load (debounced button pulse)
- rx_valid_i  in  1  UART byte available
- rx_data_i  in  8  UART byte
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o
- upg_wen_o  out  1  one-cycle memory write strobe
- upg_adr_o  out  ADR_W  word address of the write
- upg_dat_o  out  32  write data
- upg_done_o  out  1  1 = CPU owns the memory; 0 = loader owns it
- cpu_hold_o  out  1  stall/reset request to the PC/IFetch while loading
- busy_o  out  1  load in progress
- err_o  out  1  sticky abort flag (timeout or bad header)

Behaviour:
- Reset (rst=0, asynchronous) values:
  - rx_ready_o=0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0
  - upg_done_o=1, cpu_hold_o=0, busy_o=0, err_o=0
  - state=IDLE; all counters 0
- Reset asserted mid-load aborts immediately; the partial image stays in memory.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE:
  - On start_i go to HDR0; upg_done_o goes to 0 and cpu_hold_o/busy_o to 1 in the same registered cycle.
  - err_o clears on start.
- HDR0/HDR1:
  - rx_ready_o=1. Accept count[7:0], then count[15:8] (word count N, little-endian).
  - If count[15]=1 at HDR1 accept: go to ERR.
  - If N=0: go to DONE.
  - Otherwise go to DATA with the word counter, byte index and address all 0.
- DATA:
  - rx_ready_o=1. Bytes fill the shift register in order [7:0],[15:8],[23:16],[31:24].
  - On the 4th accepted byte go to WRITE; rx_ready_o=0 in WRITE.
- WRITE (exactly 1 cycle):
  - upg_wen_o=1, upg_dat_o = assembled word, upg_adr_o = current address.
  - Next cycle: address+1 (wraps at 2^ADR_W), word counter+1.
  - If words written == N go to DONE, else back to DATA.
- DONE (1 cycle): upg_done_o=1, cpu_hold_o=0, busy_o=0, then IDLE.
  - The CPU sees upg_done_o rise and restarts from PC=0 (PC logic is outside this block).
- Timeout:
  - Idle counter resets on every accepted byte and counts in HDR0/HDR1/DATA.
  - On reaching TIMEOUT_CYCLES go to ERR.
- ERR: err_o=1, cpu_hold_o stays 1, upg_done_o stays 0. Exits only via start_i (new load) or rst.
- start_i while busy (HDR0..WRITE) is ignored.
- rx_valid_i while rx_ready_o=0 is not consumed; the UART side must hold the byte.
- All outputs are registered; no combinational path from inputs to outputs.
- Load latency for N words with back-to-back bytes: 2 + 4N + N + 1 cycles from the first header byte.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams IDLE..ERR, 3 bits
  - UPG_ADR_W=15
  - DMEM_SEL_BIT=14
- One natural sub-module: upg_word_assembler. Byte-to-word shift register with a 2-bit byte index, load/clear controls and a word_full flag.
- FSM, address/word counters and timeout counter live in upg_loader_ctrl.

Test Plan:
- Reset then idle: rst low 3 cycles → upg_done_o=1, cpu_hold_o=0, all others 0. rx_valid_i with 0xAA in IDLE → rx_ready_o stays 0, no write.
- 2-word load: start_i; bytes 02 00, 78 56 34 12, EF BE AD DE → upg_wen_o pulses twice:
  - adr 0 data 0x12345678
  - adr 1 data 0xDEADBEEF
  - Then DONE 1 cycle, upg_done_o=1, cpu_hold_o=0.
- Zero-length and bad header:
  - Header 00 00 → DONE with no upg_wen_o.
  - Header 00 80 → ERR, err_o=1, upg_done_o=0.
- Timeout: TIMEOUT_CYCLES=100, send header 01 00 and 2 data bytes, then silence → err_o=1 at cycle 100 after the last byte, cpu_hold_o=1. A following start_i clears err_o.
- Flow control and start ignore: rx_valid_i held high through WRITE → byte not consumed until DATA resumes, no data lost. start_i pulsed during DATA → no restart, address continues.
- Async reset mid-DATA: rst low between bytes 2 and 3 → outputs return to reset values within the same cycle; next start_i begins at adr 0.
